trng_word_sched: RTL
====================

Name: trng_word_sched

Overview:
- Controller and scheduler in front of the `trng` core.
- Configures the core (d1/d2/d3) and sequences its reset and warm-up.
- Discards the first DISCARD valid bits, then assembles valid warbler bits into WORD_W-bit words.
- Shares the single word holding register among N_REQ requesters with round-robin grants.

Parameters:
- WORD_W, 8: random word width in bits (>=2).
- N_REQ, 2: number of requesters (>=1).
- DISCARD, 16: number of valid TRNG bits dropped after each start (>=1).
- RST_CYC, 2: cycles trng_rst is held high at start (>=1).

Ports:
- clk  in  1: single clock.
- rst_n  in  1: asynchronous, active-low reset.
- en  in  1: enable; level-sensitive.
- cfg_d1  in  1: d1 setting for the TRNG.
- cfg_d2  in  1: d2 setting for the TRNG.
- cfg_d3  in  5: d3 setting for the TRNG.
- trng_rst  out  1: active-high reset to the TRNG core.
- trng_d1  out  1: latched cfg_d1.
- trng_d2  out  1: latched cfg_d2.
- trng_d3  out  5: latched cfg_d3.
- trng_valid  in  1: TRNG o_valid.
- trng_bit  in  1: TRNG o_warbler.
- req  in  N_REQ: per-requester word request, held until granted.
- gnt  out  N_REQ: one-hot grant; the word transfers on the clock edge ending a gnt cycle.
- rdata  out  WORD_W: holding register contents; meaningful when gnt != 0.
- word_vld  out  1: holding register full.
- ready  out  1: state == COLLECT.
- ovf  out  1: sticky flag; a valid bit was dropped because both registers were full.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, trng_rst=1, trng_d1=0, trng_d2=0, trng_d3=0.
  - rdata=0, word_vld=0, ovf=0, gnt=0, rr_ptr=0, all counters and the shift register = 0.
- States and transitions:
  - IDLE: trng_rst=1. On en=1, latch cfg_* into trng_d*, clear counters, go to START.
  - START: trng_rst=1 for exactly RST_CYC cycles, then go to WARMUP with trng_rst=0.
  - WARMUP: count trng_valid pulses. trng_bit is ignored. On the DISCARD-th pulse go to COLLECT; that bit is also discarded.
  - COLLECT:
    - Each trng_valid: sreg <= {sreg[WORD_W-2:0], trng_bit}, bcnt++.
    - When bcnt reaches WORD_W:
      - If the holding register is empty, or is being granted this cycle: rdata<=sreg, word_vld<=1, bcnt<=0 on the next edge.
      - Otherwise: sreg_full=1 and the shift stops. Further valid bits are dropped and set ovf=1.
    - While sreg_full=1: load the holding register on the first cycle it frees (grant cycle or empty), then clear sreg_full.
- en=0 in any non-IDLE state:
  - Go to IDLE next cycle; trng_rst=1.
  - word_vld=0, sreg/bcnt/sreg_full cleared, ovf cleared, rr_ptr=0.
  - trng_d* hold their last value.
- cfg_* changes are ignored except when latched on the IDLE->START transition.
- Arbitration:
  - gnt is combinational from word_vld, req and rr_ptr.
  - Winner = first set req bit searching from rr_ptr upward with wrap.
  - gnt=0 when word_vld=0 or req=0.
  - On a grant to index k: word_vld<=0 (unless reloaded the same edge), rr_ptr<=(k+1) mod N_REQ.
- Simultaneous events:
  - Grant and word completion on the same edge: holding is reloaded and word_vld stays 1.
  - trng_valid in the last START cycle is ignored.
- Latency:
  - The first word is available WORD_W valid pulses after WARMUP exits.
  - word_vld rises 1 cycle after the completing valid pulse.

Decomposition:
- Package trng_sched_pkg:
  - state enum {IDLE, START, WARMUP, COLLECT}.
  - Default parameter constants.
  - Counter-width localparams via $clog2.
- Sub-module rr_arbiter (N_REQ; inputs req, ptr, en; output one-hot gnt).
- Everything else lives in the top block.

Test Plan:
- Reset and start with WORD_W=8, DISCARD=4, RST_CYC=2, bench TRNG model pulsing valid every 5th cycle:
  - rst_n low -> all outputs 0 except trng_rst=1.
  - en=1, cfg_d3=5'b10101 -> trng_d3=10101 one cycle later; trng_rst high exactly 2 cycles.
- Warm-up discard: model bits 1,1,1,1 then 1,0,1,0,0,1,1,0 -> ready rises after the 4th pulse; rdata=8'hA6; word_vld=1 one cycle after the 8th kept bit.
- Round-robin with req=2'b11 held, 3 words produced:
  - Grants go to index 0, 1, 0, each one cycle wide.
  - With req=2'b10 only, gnt=2'b10.
- Overflow with req=0 over 17 valid pulses:
  - 16 pulses -> word_vld=1, sreg_full=1.
  - The 17th pulse -> ovf=1.
  - A following grant -> the second word (sreg) loads the holding register immediately and word_vld stays 1.
- Simultaneous grant and completion: req=2'b01 asserted in the same cycle the 8th bit arrives -> gnt=2'b01 with the old word, next cycle rdata = new word, word_vld=1.
- Mid-operation disable and async reset:
  - en=0 in COLLECT -> next cycle IDLE, trng_rst=1, word_vld=0, ovf=0.
  - Re-enable -> full START/WARMUP sequence repeats.
  - rst_n pulsed mid-WARMUP -> outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/trng_word_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | trng_sched_pkg: shared types and constants for trng_word_sched   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package trng_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WARMUP  = 2'd2,
        COLLECT = 2'd3
    } state_t;

    localparam int c_def_word_w  = 8;
    localparam int c_def_n_req   = 2;
    localparam int c_def_discard = 16;
    localparam int c_def_rst_cyc = 2;

    // Bits needed to hold the values 0 .. n-1 (never less than one bit)
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int c_def_bcnt_w = cnt_w(c_def_word_w + 1);
    localparam int c_def_ptr_w  = cnt_w(c_def_n_req);

endpackage
`default_nettype wire

// File: rtl/trng_word_sched_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter: one-hot round-robin grant, searching upward from ptr |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt
);

    // Walk offsets from farthest to nearest so the nearest requester wins
    always_comb begin
        int idx;
        gnt = '0;
        idx = 0;
        if (en) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                idx = int'(ptr) + i;
                if (idx >= N_REQ) idx = idx - N_REQ;
                if (req[idx]) begin
                    gnt      = '0;
                    gnt[idx] = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/trng_word_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | trng_word_sched: TRNG config/warm-up sequencer and word scheduler |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module trng_word_sched
    import trng_sched_pkg::*;
#(
    parameter int WORD_W  = c_def_word_w,
    parameter int N_REQ   = c_def_n_req,
    parameter int DISCARD = c_def_discard,
    parameter int RST_CYC = c_def_rst_cyc
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cfg_d1,
    input  logic              cfg_d2,
    input  logic [4:0]        cfg_d3,
    output logic              trng_rst,
    output logic              trng_d1,
    output logic              trng_d2,
    output logic [4:0]        trng_d3,
    input  logic              trng_valid,
    input  logic              trng_bit,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  gnt,
    output logic [WORD_W-1:0] rdata,
    output logic              word_vld,
    output logic              ready,
    output logic              ovf
);

    localparam int c_cnt_w  = cnt_w((RST_CYC > DISCARD) ? RST_CYC : DISCARD);
    localparam int c_bcnt_w = cnt_w(WORD_W + 1);
    localparam int c_ptr_w  = cnt_w(N_REQ);

    localparam logic [c_cnt_w-1:0]  c_rst_last  = c_cnt_w'(RST_CYC - 1);
    localparam logic [c_cnt_w-1:0]  c_disc_last = c_cnt_w'(DISCARD - 1);
    localparam logic [c_bcnt_w-1:0] c_bcnt_last = c_bcnt_w'(WORD_W - 1);
    localparam logic [c_bcnt_w-1:0] c_bcnt_full = c_bcnt_w'(WORD_W);
    localparam logic [c_ptr_w-1:0]  c_ptr_last  = c_ptr_w'(N_REQ - 1);

    state_t              r_state, w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_bcnt_w-1:0] r_bcnt;
    logic [WORD_W-1:0]   r_sreg, r_rdata, w_word;
    logic                r_sreg_full, r_word_vld, r_ovf;
    logic [c_ptr_w-1:0]  r_ptr, w_gnt_idx, w_ptr_nxt;
    logic                r_d1, r_d2;
    logic [4:0]          r_d3;
    logic [N_REQ-1:0]    w_gnt;
    logic                w_grant, w_hold_free;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (c_ptr_w)
    ) u_arb (
        .req (req),
        .ptr (r_ptr),
        .en  (r_word_vld),
        .gnt (w_gnt)
    );

    always_comb begin
        w_gnt_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_gnt[k]) w_gnt_idx = c_ptr_w'(k);
        end
    end

    assign w_ptr_nxt   = (w_gnt_idx == c_ptr_last) ? '0 : w_gnt_idx + c_ptr_w'(1);
    assign w_grant     = |w_gnt;
    assign w_hold_free = !r_word_vld || w_grant;
    assign w_word      = {r_sreg[WORD_W-2:0], trng_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (en) w_state_nxt = START;
            START:   if (!en) w_state_nxt = IDLE;
                     else if (r_cnt == c_rst_last) w_state_nxt = WARMUP;
            WARMUP:  if (!en) w_state_nxt = IDLE;
                     else if (trng_valid && (r_cnt == c_disc_last)) w_state_nxt = COLLECT;
            COLLECT: if (!en) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_bcnt      <= '0;
            r_sreg      <= '0;
            r_rdata     <= '0;
            r_sreg_full <= 1'b0;
            r_word_vld  <= 1'b0;
            r_ovf       <= 1'b0;
            r_ptr       <= '0;
            r_d1        <= 1'b0;
            r_d2        <= 1'b0;
            r_d3        <= '0;
        end else if ((r_state != IDLE) && !en) begin
            // Abort: drop all collected data but keep the core configuration
            r_cnt       <= '0;
            r_bcnt      <= '0;
            r_sreg      <= '0;
            r_sreg_full <= 1'b0;
            r_word_vld  <= 1'b0;
            r_ovf       <= 1'b0;
            r_ptr       <= '0;
        end else begin
            case (r_state)
                IDLE: if (en) begin
                    r_d1        <= cfg_d1;
                    r_d2        <= cfg_d2;
                    r_d3        <= cfg_d3;
                    r_cnt       <= '0;
                    r_bcnt      <= '0;
                    r_sreg      <= '0;
                    r_sreg_full <= 1'b0;
                end
                START:  r_cnt <= (r_cnt == c_rst_last) ? '0 : r_cnt + c_cnt_w'(1);
                WARMUP: if (trng_valid) begin
                    r_cnt <= (r_cnt == c_disc_last) ? '0 : r_cnt + c_cnt_w'(1);
                end
                COLLECT: begin
                    if (w_grant) begin
                        r_word_vld <= 1'b0;
                        r_ptr      <= w_ptr_nxt;
                    end
                    if (r_sreg_full) begin
                        // A bit arriving on the freeing edge starts the next word
                        if (w_hold_free) begin
                            r_rdata     <= r_sreg;
                            r_word_vld  <= 1'b1;
                            r_sreg_full <= 1'b0;
                            if (trng_valid) begin
                                r_sreg <= w_word;
                                r_bcnt <= c_bcnt_w'(1);
                            end else begin
                                r_bcnt <= '0;
                            end
                        end else if (trng_valid) begin
                            r_ovf <= 1'b1;
                        end
                    end else if (trng_valid) begin
                        r_sreg <= w_word;
                        if (r_bcnt == c_bcnt_last) begin
                            if (w_hold_free) begin
                                r_rdata    <= w_word;
                                r_word_vld <= 1'b1;
                                r_bcnt     <= '0;
                            end else begin
                                r_bcnt      <= c_bcnt_full;
                                r_sreg_full <= 1'b1;
                            end
                        end else begin
                            r_bcnt <= r_bcnt + c_bcnt_w'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign trng_rst = (r_state == IDLE) || (r_state == START);
    assign trng_d1  = r_d1;
    assign trng_d2  = r_d2;
    assign trng_d3  = r_d3;
    assign gnt      = w_gnt;
    assign rdata    = r_rdata;
    assign word_vld = r_word_vld;
    assign ready    = (r_state == COLLECT);
    assign ovf      = r_ovf;

endmodule
`default_nettype wire
